// File: rtl/scroll_ctrl.sv
// scroll_ctrl: message buffer plus a sliding WIN-character window that advances once per timer period.
// Build macro SCROLL_BOUNCE_EN selects ping-pong scrolling; without it the window wraps around the message.
module scroll_ctrl #(
   parameter int MSG_DEPTH = 32,
   parameter int WIN       = 4,
   parameter int CHAR_W    = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          enable,
   input  logic                          wr_en,
   input  logic [$clog2(MSG_DEPTH)-1:0]  wr_addr,
   input  logic [CHAR_W-1:0]             wr_data,
   input  logic [$clog2(MSG_DEPTH):0]    msg_len,
   input  logic [31:0]                   period,
   output logic                          cnt_start,
   output logic [31:0]                   cnt_value,
   input  logic                          cnt_done,
   output logic [WIN*CHAR_W-1:0]         disp_chars,
   output logic                          frame_valid,
   output logic                          busy,
   output logic [2:0]                    dbg_state,
   output logic [$clog2(MSG_DEPTH)-1:0]  dbg_pos
);

   localparam int AW = $clog2(MSG_DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0]         ONE_L  = LW'(1);
   localparam logic [CHAR_W-1:0]     SPACE  = CHAR_W'(8'h20);
   localparam logic [WIN*CHAR_W-1:0] SPACES = {WIN{SPACE}};

   // Timer handshake: cnt_start is a one-cycle request (ARM) carrying cnt_value; the timer answers
   // with a one-cycle cnt_done period+1 cycles later, which is only honoured while in WAIT.
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ARM, S_WAIT, S_STEP} state_t;

   state_t                 state_q, state_d;
   logic [AW-1:0]          pos_q, pos_d;
   logic [31:0]            cnt_value_q;
   logic [WIN*CHAR_W-1:0]  disp_q, win_d;
   logic                   fv_q;
   logic [CHAR_W-1:0]      mem_q [MSG_DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_addr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (!enable) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:  state_d = S_LOAD;
            S_LOAD:  state_d = S_ARM;
            S_ARM:   state_d = S_WAIT;
            S_WAIT:  if (cnt_done) state_d = S_STEP;
            S_STEP:  state_d = S_LOAD;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      busy      = (state_q != S_IDLE);
      cnt_start = (state_q == S_ARM) && rst_n;
      dbg_state = state_q;
   end

`ifdef SCROLL_BOUNCE_EN
   logic          dir_q, dir_d;
   logic [AW-1:0] lim;

   // dir_q = 1 means moving backward; lim is the last position that still fills the window.
   always_comb begin
      lim   = (msg_len > LW'(WIN)) ? AW'(msg_len - LW'(WIN)) : '0;
      pos_d = pos_q;
      dir_d = dir_q;
      if (msg_len <= LW'(WIN)) begin
         pos_d = '0;
         dir_d = 1'b0;
      end else if (!dir_q) begin
         if (LW'(pos_q) + ONE_L >= LW'(lim)) begin
            pos_d = lim;
            dir_d = 1'b1;
         end else begin
            pos_d = pos_q + 1'b1;
         end
      end else begin
         if (pos_q > lim) begin
            pos_d = lim;
         end else if (LW'(pos_q) <= ONE_L) begin
            pos_d = '0;
            dir_d = 1'b0;
         end else begin
            pos_d = pos_q - 1'b1;
         end
      end
   end

   always_comb begin
      logic [LW-1:0] bidx;
      win_d = SPACES;
      for (int i = 0; i < WIN; i++) begin
         bidx = LW'(pos_q) + LW'(i);
         if (bidx < msg_len) win_d[i*CHAR_W +: CHAR_W] = mem_q[bidx[AW-1:0]];
      end
   end
`else
   always_comb begin
      pos_d = (LW'(pos_q) + ONE_L >= msg_len) ? '0 : pos_q + 1'b1;
   end

   // Walk the buffer with a wrapping index; a stale pos beyond a shrunk length restarts at 0.
   always_comb begin
      logic [AW-1:0] idx;
      win_d = SPACES;
      idx   = (LW'(pos_q) >= msg_len) ? '0 : pos_q;
      for (int i = 0; i < WIN; i++) begin
         if (msg_len != '0) win_d[i*CHAR_W +: CHAR_W] = mem_q[idx];
         idx = (LW'(idx) + ONE_L >= msg_len) ? '0 : idx + 1'b1;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pos_q       <= '0;
         cnt_value_q <= '0;
         disp_q      <= SPACES;
         fv_q        <= 1'b0;
`ifdef SCROLL_BOUNCE_EN
         dir_q       <= 1'b0;
`endif
      end else begin
         fv_q <= 1'b0;
         if (state_d == S_IDLE) begin
            pos_q <= '0;
`ifdef SCROLL_BOUNCE_EN
            dir_q <= 1'b0;
`endif
         end else if (state_q == S_STEP) begin
            pos_q <= pos_d;
`ifdef SCROLL_BOUNCE_EN
            dir_q <= dir_d;
`endif
         end
         if (state_q == S_LOAD && enable) begin
            disp_q <= win_d;
            fv_q   <= 1'b1;
         end
         if (state_q == S_LOAD && state_d == S_ARM) cnt_value_q <= period;
      end
   end

   assign cnt_value   = cnt_value_q;
   assign disp_chars  = disp_q;
   assign frame_valid = fv_q;
   assign dbg_pos     = pos_q;

endmodule
